// File: rtl/tdm_pkg.sv
// Shared constants, state type and O-slicing helper for the TDM demultiplexer.
// Frame geometry depends on TDM_DEMUX_PARITY_EN (adds a trailing parity slot).
package tdm_pkg;

  localparam int FRAME_CH = 4;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int NUM_SLOTS = FRAME_CH + 1;
  localparam int SLOT_W    = 3;
`else
  localparam int NUM_SLOTS = FRAME_CH;
  localparam int SLOT_W    = 2;
`endif

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Base bit of channel k inside the flattened parallel output.
  function automatic int ch_slice(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-NUM_SLOTS slot counter: load-to-1, increment with wrap, hold, last-slot flag.
// Frame length follows TDM_DEMUX_PARITY_EN through tdm_pkg.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its inputs, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (load) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= last ? '0 : slot + SLOT_W'(1);
    end
  end

  assign last = (slot == LAST_SLOT);

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM de-serialiser: frame-sync locked slot steering, staging and
// registered frame output. TDM_DEMUX_PARITY_EN adds a fifth even-parity slot.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int NUM_CH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     frame_sync,
  output logic [NUM_CH*DATA_W-1:0] O,
  output logic                     frame_valid,
  output logic [SLOT_W-1:0]        S,
  output logic                     locked,
  output logic                     sync_err,
  output logic                     parity_err
);

  state_e                     state;
  state_e                     state_next;
  logic [SLOT_W-1:0]          slot;
  logic                       last;
  logic                       cnt_load;
  logic                       cnt_inc;
  logic                       complete;
  logic                       sync_err_d;
  logic                       parity_ok;
  logic                       parity_err_q;
  logic [DATA_W-1:0]          staging [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]   frame_word;

  tdm_slot_counter u_slot_counter (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .inc  (cnt_inc),
    .slot (slot),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // HUNT leaves only on a qualified sync beat; LOCKED is only left by reset.
  always_comb begin
    state_next = state;
    case (state)
      HUNT:    if (din_valid && frame_sync) state_next = LOCKED;
      LOCKED:  state_next = LOCKED;
      default: state_next = HUNT;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    complete   = 1'b0;
    sync_err_d = 1'b0;
    if (din_valid) begin
      if (state == HUNT) begin
        cnt_load = frame_sync;
      end else if (frame_sync && (slot != '0)) begin
        // Misplaced marker: drop the partial frame and restart on this beat.
        cnt_load   = 1'b1;
        sync_err_d = 1'b1;
      end else begin
        cnt_inc  = 1'b1;
        complete = last;
      end
    end
  end

  assign locked = (state == LOCKED);
  assign S      = slot;

  // NOTE: the staging array is small and is reset so a partial frame never
  // leaks stale data; larger storage would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) staging[k] <= '0;
    end else if (cnt_load) begin
      staging[0] <= din;
    end else if (cnt_inc) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (slot == SLOT_W'(k)) staging[k] <= din;
      end
    end
  end

  always_comb begin
    frame_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      frame_word[ch_slice(k, DATA_W) +: DATA_W] = staging[k];
    end
`ifndef TDM_DEMUX_PARITY_EN
    // The last data beat bypasses staging so O is ready one cycle later.
    frame_word[ch_slice(NUM_CH - 1, DATA_W) +: DATA_W] = din;
`endif
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Parity beat carries the even parity of all data bits in its LSB.
  assign parity_ok  = ((^frame_word) == din[0]);
  assign parity_err = parity_err_q;
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      O            <= '0;
      frame_valid  <= 1'b0;
      sync_err     <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_valid  <= complete && parity_ok;
      sync_err     <= sync_err_d;
      parity_err_q <= complete && !parity_ok;
      if (complete && parity_ok) O <= frame_word;
    end
  end

endmodule
